// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter sharing one simple-bus AXI4-Lite manager between two requesters.
// Define ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES, timeoutErr).
module simple_bus_arbiter #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESET,
  input  logic [1:0]              reqWr,
  input  logic [2*ADDR_WIDTH-1:0] reqWrAddr,
  input  logic [2*DATA_WIDTH-1:0] reqWrData,
  output logic [1:0]              reqWrDone,
  input  logic [1:0]              reqRd,
  input  logic [2*ADDR_WIDTH-1:0] reqRdAddr,
  output logic [DATA_WIDTH-1:0]   reqRdData,
  output logic [1:0]              reqRdDone,
  output logic                    timeoutErr,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   wrAddr,
  output logic [DATA_WIDTH-1:0]   wrData,
  output logic                    wr,
  input  logic                    wrDone,
  output logic [ADDR_WIDTH-1:0]   rdAddr,
  output logic                    rd,
  input  logic [DATA_WIDTH-1:0]   rdData,
  input  logic                    rdDone
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic   grant, op_rd, last_grant;
  logic   [1:0] active;
  logic   win, win_rd;
  logic   match_done, wait_exit;

  // Contention goes to the requester not served last; a lone requester always wins.
  always_comb begin
    active     = reqWr | reqRd;
    win        = (active == 2'b11) ? ~last_grant : active[1];
    win_rd     = ~reqWr[win];
    match_done = op_rd ? rdDone : wrDone;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          tmo_hit, timed_out;

  assign tmo_hit   = (state == WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign wait_exit = match_done | tmo_hit;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE:    timed_out <= 1'b0;
        ISSUE:   wait_cnt  <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!match_done && tmo_hit) timed_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign wait_exit = match_done;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|active) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_exit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, op and manager-side address/data are latched once per grant.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      grant      <= 1'b0;
      op_rd      <= 1'b0;
      last_grant <= 1'b1;
      wrAddr     <= '0;
      wrData     <= '0;
      rdAddr     <= '0;
      reqRdData  <= '0;
    end else begin
      case (state)
        IDLE: if (|active) begin
          grant <= win;
          op_rd <= win_rd;
          if (win_rd) begin
            rdAddr <= win ? reqRdAddr[ADDR_WIDTH +: ADDR_WIDTH] : reqRdAddr[0 +: ADDR_WIDTH];
          end else begin
            wrAddr <= win ? reqWrAddr[ADDR_WIDTH +: ADDR_WIDTH] : reqWrAddr[0 +: ADDR_WIDTH];
            wrData <= win ? reqWrData[DATA_WIDTH +: DATA_WIDTH] : reqWrData[0 +: DATA_WIDTH];
          end
        end
        WAIT: begin
          if (match_done) begin
            if (op_rd) reqRdData <= rdData;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_hit && op_rd) reqRdData <= '1;
`endif
        end
        DONE: last_grant <= grant;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr         = 1'b0;
    rd         = 1'b0;
    reqWrDone  = '0;
    reqRdDone  = '0;
    timeoutErr = 1'b0;
    busy       = (state != IDLE);
    case (state)
      ISSUE: begin
        wr = ~op_rd;
        rd = op_rd;
      end
      DONE: begin
        if (op_rd) reqRdDone[grant] = 1'b1;
        else       reqWrDone[grant] = 1'b1;
`ifdef ARB_TIMEOUT_EN
        timeoutErr = timed_out;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Scoreboard bench for simple_bus_arbiter: a manager model answers strobes and a monitor
// pops expected transactions as requester done pulses appear.
`timescale 1ns/1ps
module tb_simple_bus_arbiter;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      reqWr, reqRd, reqWrDone, reqRdDone;
  logic [2*AW-1:0] reqWrAddr, reqRdAddr;
  logic [2*DW-1:0] reqWrData;
  logic [DW-1:0]   reqRdData, wrData, rdData;
  logic [AW-1:0]   wrAddr, rdAddr;
  logic            timeoutErr, busy, wr, wrDone, rd, rdDone;

  typedef struct {
    bit            is_rd;
    int            r;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            tmo;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            errors = 0, checks = 0, cyc = 0;
  int            mgr_done_cyc = -100, strobe_cyc = -100;
  bit            mgr_en = 1'b1;
  logic [DW-1:0] rd_value = '0;
  int            spur_cnt = 0, spur_seen = 0;
  bit            spur_rd = 1'b0;
  bit            prev_strobe = 1'b0;

  simple_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .reqWr(reqWr),
    .reqWrAddr(reqWrAddr),
    .reqWrData(reqWrData),
    .reqWrDone(reqWrDone),
    .reqRd(reqRd),
    .reqRdAddr(reqRdAddr),
    .reqRdData(reqRdData),
    .reqRdDone(reqRdDone),
    .timeoutErr(timeoutErr),
    .busy(busy),
    .wrAddr(wrAddr),
    .wrData(wrData),
    .wr(wr),
    .wrDone(wrDone),
    .rdAddr(rdAddr),
    .rd(rd),
    .rdData(rdData),
    .rdDone(rdDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push(input bit is_rd, input int r, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input bit tmo);
    exp_t e;
    e.is_rd = is_rd; e.r = r; e.addr = a; e.data = d; e.tmo = tmo;
    exp_q.push_back(e);
  endfunction

  // Manager model: answers each strobe one cycle later; can inject stray done pulses.
  initial begin
    wrDone = 1'b0;
    rdDone = 1'b0;
    rdData = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        if (spur_rd) begin rdDone = 1'b1; rdData = 32'h0BAD_0BAD; end
        else wrDone = 1'b1;
        @(negedge clk);
        rdDone = 1'b0; wrDone = 1'b0; rdData = 32'hDEAD_BEEF;
      end else if ((wr || rd) && mgr_en) begin
        if (rd) begin
          @(negedge clk);
          rdDone = 1'b1; rdData = rd_value;
        end else begin
          @(negedge clk);
          wrDone = 1'b1;
        end
        mgr_done_cyc = cyc;
        @(negedge clk);
        rdDone = 1'b0; wrDone = 1'b0; rdData = 32'hDEAD_BEEF;
      end
    end
  end

  always @(negedge clk) begin
    if (wr || rd) begin
      strobe_cyc = cyc;
      check("strobe_single_cycle", prev_strobe, 0);
      if (exp_q.size() == 0) check("unexpected_strobe", {wr, rd}, 0);
      else begin
        check("strobe_kind", {wr, rd}, exp_q[0].is_rd ? 2'b01 : 2'b10);
        if (exp_q[0].is_rd) check("rdAddr", rdAddr, exp_q[0].addr);
        else begin
          check("wrAddr", wrAddr, exp_q[0].addr);
          check("wrData", wrData, exp_q[0].data);
        end
      end
    end
    if (|reqWrDone || |reqRdDone) begin
      if (exp_q.size() == 0) check("unexpected_done", {reqWrDone, reqRdDone}, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("done_vector", {reqWrDone, reqRdDone},
              mon_e.is_rd ? {2'b00, 2'(1 << mon_e.r)} : {2'(1 << mon_e.r), 2'b00});
        check("timeoutErr", timeoutErr, mon_e.tmo);
        if (mon_e.is_rd) check("reqRdData", reqRdData, mon_e.data);
        if (mon_e.tmo) check("timeout_latency", cyc - strobe_cyc, TMO + 1);
        else           check("done_latency", cyc - mgr_done_cyc, 1);
      end
    end else if (timeoutErr) begin
      check("stray_timeoutErr", timeoutErr, 0);
    end
    prev_strobe = wr || rd;
  end

  task automatic req_op(input int r, input bit is_rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (is_rd) begin
      reqRdAddr[r*AW +: AW] = a;
      reqRd[r] = 1'b1;
    end else begin
      reqWrAddr[r*AW +: AW] = a;
      reqWrData[r*DW +: DW] = d;
      reqWr[r] = 1'b1;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (is_rd ? reqRdDone[r] : reqWrDone[r]) got = 1'b1;
    end
    if (is_rd) reqRd[r] = 1'b0;
    else       reqWr[r] = 1'b0;
    if (!got) check("request_timed_out", 0, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    rst = 1'b1;
    reqWr = '0; reqRd = '0;
    reqWrAddr = '0; reqRdAddr = '0; reqWrData = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {busy, wr, rd, reqWrDone, reqRdDone, timeoutErr}, 0);
    check("reset_addr", {wrAddr, rdAddr}, 0);
    check("reset_data", {wrData, reqRdData}, 0);

    // single write from requester 0
    push(1'b0, 0, 4'h4, 32'hA5A5_0001, 1'b0);
    req_op(0, 1'b0, 4'h4, 32'hA5A5_0001);

    // single read from requester 1
    rd_value = 32'h1234_5678;
    push(1'b1, 1, 4'h4, 32'h1234_5678, 1'b0);
    req_op(1, 1'b1, 4'h4, '0);

    // contention from reset: expect 0,1,0,1
    pulse_reset();
    push(1'b0, 0, 4'h1, 32'h1000_0001, 1'b0);
    push(1'b0, 1, 4'h2, 32'h2000_0002, 1'b0);
    push(1'b0, 0, 4'h3, 32'h3000_0003, 1'b0);
    push(1'b0, 1, 4'h5, 32'h4000_0004, 1'b0);
    fork
      begin
        req_op(0, 1'b0, 4'h1, 32'h1000_0001);
        req_op(0, 1'b0, 4'h3, 32'h3000_0003);
      end
      begin
        req_op(1, 1'b0, 4'h2, 32'h2000_0002);
        req_op(1, 1'b0, 4'h5, 32'h4000_0004);
      end
    join

    // same requester write+read: write first, read data only from rdDone
    rd_value = 32'hCAFE_F00D;
    push(1'b0, 0, 4'h8, 32'h5555_AAAA, 1'b0);
    push(1'b1, 0, 4'h8, 32'hCAFE_F00D, 1'b0);
    fork
      req_op(0, 1'b0, 4'h8, 32'h5555_AAAA);
      req_op(0, 1'b1, 4'h8, '0);
      begin
        for (int i = 0; i < 100 && !reqWrDone[0]; i++) @(negedge clk);
        check("rdData_held_during_write", reqRdData, 32'h0);
      end
    join

    // reset while waiting on the manager
    mgr_en = 1'b0;
    push(1'b1, 1, 4'h3, '0, 1'b0);
    @(negedge clk);
    reqRdAddr[AW +: AW] = 4'h3;
    reqRd[1] = 1'b1;
    for (int i = 0; i < 20 && !rd; i++) @(negedge clk);
    spur_rd = 1'b0;
    spur_cnt++;
    repeat (3) @(negedge clk);
    check("wait_ignores_wrDone", busy, 1);
    rst = 1'b1;
    reqRd[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_ctrl", {busy, wr, rd, reqWrDone, reqRdDone, timeoutErr}, 0);
    check("midreset_regs", {wrAddr, rdAddr, reqRdData}, 0);
    check("midreset_no_done", exp_q.size(), 1);
    exp_q.delete();
    spur_rd = 1'b1;
    spur_cnt++;
    repeat (4) @(negedge clk);
    check("idle_ignores_rdDone", {busy, reqRdData}, 0);

`ifdef ARB_TIMEOUT_EN
    push(1'b1, 0, 4'h5, 32'hFFFF_FFFF, 1'b1);
    req_op(0, 1'b1, 4'h5, '0);
`endif
    mgr_en = 1'b1;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
